// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register.
// Captures the decoder control bundle, operands, immediate, PC+4 and register
// specifiers for the EX stage, with hazard-unit stall (hold) and flush (bubble)
// support and a saturating count of injected bubbles for performance debug.
module id_ex_reg #(
   parameter int unsigned WIDTH   = 32'd32,
   parameter int unsigned REGBITS = 32'd5,
   parameter int unsigned CNTW    = 32'd16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_e,
   input  logic               flush_e,
   input  logic               valid_d,
   input  logic               regwrite_d,
   input  logic               memtoreg_d,
   input  logic               memwrite_d,
   input  logic               branch_d,
   input  logic               bne_d,
   input  logic               alusrc_d,
   input  logic               jump_d,
   input  logic               jal_d,
   input  logic               lb_d,
   input  logic [1:0]         regdst_d,
   input  logic [1:0]         aluop_d,
   input  logic [WIDTH-1:0]   rd1_d,
   input  logic [WIDTH-1:0]   rd2_d,
   input  logic [WIDTH-1:0]   signimm_d,
   input  logic [WIDTH-1:0]   pcplus4_d,
   input  logic [REGBITS-1:0] rs_d,
   input  logic [REGBITS-1:0] rt_d,
   input  logic [REGBITS-1:0] rd_d,
   output logic               regwrite_e,
   output logic               memtoreg_e,
   output logic               memwrite_e,
   output logic               branch_e,
   output logic               bne_e,
   output logic               alusrc_e,
   output logic               jump_e,
   output logic               jal_e,
   output logic               lb_e,
   output logic [1:0]         regdst_e,
   output logic [1:0]         aluop_e,
   output logic [WIDTH-1:0]   rd1_e,
   output logic [WIDTH-1:0]   rd2_e,
   output logic [WIDTH-1:0]   signimm_e,
   output logic [WIDTH-1:0]   pcplus4_e,
   output logic [REGBITS-1:0] rs_e,
   output logic [REGBITS-1:0] rt_e,
   output logic [REGBITS-1:0] rd_e,
   output logic [REGBITS-1:0] writereg_e,
   output logic               valid_e,
   output logic [CNTW-1:0]    bubble_count
);

   // Control bundle: 9 single-bit flags plus regdst and aluop.
   localparam int unsigned CTLW = 32'd13;

   localparam logic [REGBITS-1:0] REG_RA   = REGBITS'(5'd31);
   localparam logic [CNTW-1:0]    CNT_MAX  = {CNTW{1'b1}};
   localparam logic [CNTW-1:0]    CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CTLW-1:0]    CTL_ZERO = {CTLW{1'b0}};
   localparam logic [WIDTH-1:0]   DAT_ZERO = {WIDTH{1'b0}};
   localparam logic [REGBITS-1:0] REG_ZERO = {REGBITS{1'b0}};
   localparam logic [CNTW-1:0]    CNT_ZERO = {CNTW{1'b0}};

   // Destination register selected by the decoder's regdst field.
   function automatic logic [REGBITS-1:0] resolve_writereg(
      input logic [1:0]         regdst,
      input logic [REGBITS-1:0] rt,
      input logic [REGBITS-1:0] rd
   );
      logic [REGBITS-1:0] wr;
      case (regdst)
         2'b00:   wr = rt;
         2'b01:   wr = rd;
         2'b10:   wr = REG_RA;
         2'b11:   wr = rd;
         default: wr = rd;
      endcase
      return wr;
   endfunction

   logic [CTLW-1:0]    ctl_r;
   logic [CTLW-1:0]    ctl_d_s;
   logic [CTLW-1:0]    ctl_next_s;
   logic [REGBITS-1:0] writereg_next_s;
   logic [CNTW-1:0]    count_inc_s;

   // Gate decoder controls with valid_d so X from illegal opcodes never reaches EX,
   // and form the saturating increment of the bubble counter.
   always_comb begin
      ctl_d_s         = {regwrite_d, memtoreg_d, memwrite_d, branch_d, bne_d,
                         alusrc_d, jump_d, jal_d, lb_d, regdst_d, aluop_d};
      ctl_next_s      = CTL_ZERO;
      writereg_next_s = REG_ZERO;
      count_inc_s     = bubble_count;
      if (valid_d) begin
         ctl_next_s      = ctl_d_s;
         writereg_next_s = resolve_writereg(regdst_d, rt_d, rd_d);
      end else begin
         ctl_next_s      = CTL_ZERO;
         writereg_next_s = REG_ZERO;
      end
      if (bubble_count != CNT_MAX) begin
         count_inc_s = bubble_count + CNT_ONE;
      end else begin
         count_inc_s = bubble_count;
      end
   end

   // Pipeline register: reset clears, flush loads a bubble, stall holds, else load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctl_r        <= CTL_ZERO;
         rd1_e        <= DAT_ZERO;
         rd2_e        <= DAT_ZERO;
         signimm_e    <= DAT_ZERO;
         pcplus4_e    <= DAT_ZERO;
         rs_e         <= REG_ZERO;
         rt_e         <= REG_ZERO;
         rd_e         <= REG_ZERO;
         writereg_e   <= REG_ZERO;
         valid_e      <= 1'b0;
         bubble_count <= CNT_ZERO;
      end else if (flush_e) begin
         ctl_r        <= CTL_ZERO;
         rd1_e        <= DAT_ZERO;
         rd2_e        <= DAT_ZERO;
         signimm_e    <= DAT_ZERO;
         pcplus4_e    <= DAT_ZERO;
         rs_e         <= REG_ZERO;
         rt_e         <= REG_ZERO;
         rd_e         <= REG_ZERO;
         writereg_e   <= REG_ZERO;
         valid_e      <= 1'b0;
         bubble_count <= count_inc_s;
      end else if (!stall_e) begin
         ctl_r        <= ctl_next_s;
         rd1_e        <= rd1_d;
         rd2_e        <= rd2_d;
         signimm_e    <= signimm_d;
         pcplus4_e    <= pcplus4_d;
         rs_e         <= rs_d;
         rt_e         <= rt_d;
         rd_e         <= rd_d;
         writereg_e   <= writereg_next_s;
         valid_e      <= valid_d;
         if (!valid_d) begin
            bubble_count <= count_inc_s;
         end
      end
   end

   assign {regwrite_e, memtoreg_e, memwrite_e, branch_e, bne_e,
           alusrc_e, jump_e, jal_e, lb_e, regdst_e, aluop_e} = ctl_r;

endmodule
